// File: rtl/rggen_external_register_window_if.sv
// Register-bus and external-bus interfaces used by the multi-window external register bridge.
// Register side carries one CSR access; bus side is one external master per window.
interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       valid;
    logic [1:0]                 access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       active;
    logic                       ready;
    logic [1:0]                 status;
    logic [BUS_WIDTH-1:0]       read_data;
    logic [BUS_WIDTH-1:0]       value;

    modport host (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data, value
    );

    modport register (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data, value
    );
endinterface

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       valid;
    logic [1:0]                 access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    logic [1:0]                 status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_external_register_window.sv
// Routes CSR accesses hitting one of WINDOWS address ranges to that window's external master.
// Latency >= 2 cycles; holds the request until the slave answers or the timeout aborts it.
module rggen_external_register_window #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int WINDOWS       = 2,
    parameter bit [ADDRESS_WIDTH-1:0] START_ADDRESS [WINDOWS] = '{default: '0},
    parameter bit [ADDRESS_WIDTH-1:0] END_ADDRESS   [WINDOWS] = '{default: '0},
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    rggen_register_if.register  register_if,
    rggen_bus_if.master         bus_if [WINDOWS]
);
    localparam int WW = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int SW = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_e;

    state_e                     state_q;
    logic [WW-1:0]              win_q;
    logic [WINDOWS-1:0]         valid_q;
    logic [1:0]                 access_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [BUS_WIDTH-1:0]       wdata_q;
    logic [SW-1:0]              strobe_q;
    logic                       ready_q;
    logic [1:0]                 status_q;
    logic [BUS_WIDTH-1:0]       rdata_q;
    logic [BUS_WIDTH-1:0]       value_q;
    logic [CW-1:0]              count_q;

    logic                       hit;
    logic [WW-1:0]              hit_idx;
    logic [ADDRESS_WIDTH-1:0]   hit_offset;

    logic [WINDOWS-1:0]                 bus_ready;
    logic [WINDOWS-1:0][1:0]            bus_status;
    logic [WINDOWS-1:0][BUS_WIDTH-1:0]  bus_rdata;

    logic                       sel_ready;
    logic [1:0]                 sel_status;
    logic [BUS_WIDTH-1:0]       sel_rdata;
    logic                       timeout_hit;

    // Scanning from the top down lets the lowest matching window overwrite the others.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_offset = '0;
        for (int k = WINDOWS - 1; k >= 0; k--) begin
            if ((register_if.address >= START_ADDRESS[k]) &&
                (register_if.address <= END_ADDRESS[k])) begin
                hit        = 1'b1;
                hit_idx    = WW'(k);
                hit_offset = register_if.address - START_ADDRESS[k];
            end
        end
    end

    for (genvar g = 0; g < WINDOWS; g++) begin : g_window
        assign bus_if[g].valid      = valid_q[g];
        assign bus_if[g].access     = access_q;
        assign bus_if[g].address    = address_q;
        assign bus_if[g].write_data = wdata_q;
        assign bus_if[g].strobe     = strobe_q;
        assign bus_ready[g]         = bus_if[g].ready;
        assign bus_status[g]        = bus_if[g].status;
        assign bus_rdata[g]         = bus_if[g].read_data;
    end

    assign sel_ready   = bus_ready[win_q];
    assign sel_status  = bus_status[win_q];
    assign sel_rdata   = bus_rdata[win_q];
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (count_q == CW'(TIMEOUT_CYCLES));

    assign register_if.active    = register_if.valid && hit;
    assign register_if.ready     = ready_q;
    assign register_if.status    = status_q;
    assign register_if.read_data = rdata_q;
    assign register_if.value     = value_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            valid_q   <= '0;
            access_q  <= '0;
            address_q <= '0;
            wdata_q   <= '0;
            strobe_q  <= '0;
            ready_q   <= 1'b0;
            status_q  <= '0;
            rdata_q   <= '0;
            value_q   <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (register_if.valid && hit) begin
                        state_q   <= BUSY;
                        win_q     <= hit_idx;
                        valid_q   <= WINDOWS'(1) << hit_idx;
                        access_q  <= register_if.access;
                        address_q <= hit_offset;
                        wdata_q   <= register_if.write_data;
                        strobe_q  <= register_if.strobe;
                        count_q   <= '0;
                    end
                end
                BUSY: begin
                    // A ready arriving on the expiry cycle still delivers the real response.
                    if (sel_ready) begin
                        state_q  <= RESPOND;
                        valid_q  <= '0;
                        ready_q  <= 1'b1;
                        status_q <= sel_status;
                        rdata_q  <= sel_rdata;
                        value_q  <= sel_rdata;
                    end else if (timeout_hit) begin
                        state_q  <= RESPOND;
                        valid_q  <= '0;
                        ready_q  <= 1'b1;
                        status_q <= 2'b10;
                        rdata_q  <= '0;
                        value_q  <= '0;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= '0;
                end
            endcase
        end
    end
endmodule
